// File: rtl/mem_ctrl.sv
// Byte-wide memory controller that serves instruction fetches and load/store
// requests over a single 8-bit RAM port, giving load/store priority over fetch.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic [31:0] if_data_out,
    output logic        if_done_out,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [2:0]  mem_len_in,
    output logic [31:0] mem_rdata_out,
    output logic        mem_done_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic        if_stall_req_out,
    output logic        mem_stall_req_out
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt, cnt_inc, len_q;
    logic [1:0]  cap_idx;
    logic [31:0] addr_q, wdata_q, rbuf, rbuf_nxt;

    function automatic logic [2:0] decode_len(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    assign cnt_inc = cnt + 3'd1;
    assign cap_idx = cnt[1:0] - 2'd1;

    assign if_stall_req_out  = if_req_in  & ~if_done_out;
    assign mem_stall_req_out = mem_req_in & ~mem_done_out;

    // RAM read data lags the address by one cycle, so byte cnt-1 arrives while cnt is current
    always_comb begin
        rbuf_nxt = rbuf;
        if (cnt != 3'd0)
            rbuf_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                if (mem_req_in)
                    state_nxt = mem_we_in ? MEM_WR : MEM_RD;
                else if (if_req_in)
                    state_nxt = IF_RD;
            end
            IF_RD, MEM_RD: begin
                if (cnt == len_q) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            MEM_WR: begin
                if (cnt_inc == len_q) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= 3'd0;
            len_q <= 3'd4;
        end else if (rdy_in) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE)
                len_q <= mem_req_in ? decode_len(mem_len_in) : 3'd4;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && state == IDLE) begin
            addr_q  <= mem_req_in ? mem_addr_in : if_addr_in;
            wdata_q <= mem_wdata_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            if_data_out   <= 32'd0;
            if_done_out   <= 1'b0;
            mem_rdata_out <= 32'd0;
            mem_done_out  <= 1'b0;
            mem_dout      <= 8'd0;
            mem_a         <= 32'd0;
            mem_wr        <= 1'b0;
            rbuf          <= 32'd0;
        end else if (rdy_in) begin
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req_in) begin
                        mem_a    <= mem_addr_in;
                        mem_wr   <= mem_we_in;
                        mem_dout <= mem_we_in ? mem_wdata_in[7:0] : 8'd0;
                        rbuf     <= 32'd0;
                    end else if (if_req_in) begin
                        mem_a  <= if_addr_in;
                        mem_wr <= 1'b0;
                        rbuf   <= 32'd0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (cnt == len_q) begin
                        if (state == IF_RD) begin
                            if_data_out <= rbuf_nxt;
                            if_done_out <= 1'b1;
                        end else begin
                            mem_rdata_out <= rbuf_nxt;
                            mem_done_out  <= 1'b1;
                        end
                    end else begin
                        rbuf <= rbuf_nxt;
                        if (cnt_inc < len_q)
                            mem_a <= addr_q + {29'd0, cnt_inc};
                    end
                end
                MEM_WR: begin
                    if (cnt_inc < len_q) begin
                        mem_a    <= addr_q + {29'd0, cnt_inc};
                        mem_dout <= pick_byte(wdata_q, cnt_inc[1:0]);
                    end else begin
                        mem_wr       <= 1'b0;
                        mem_done_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model on the DUT port, a byte-map
// reference of memory contents, and a monitor that checks every completion and write beat.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req_in, mem_req_in, mem_we_in;
    logic [31:0] if_addr_in, mem_addr_in, mem_wdata_in;
    logic [2:0]  mem_len_in;
    logic [7:0]  mem_din = 8'd0;
    logic [31:0] if_data_out, mem_rdata_out, mem_a;
    logic        if_done_out, mem_done_out, mem_wr;
    logic [7:0]  mem_dout;
    logic        if_stall_req_out, mem_stall_req_out;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_data_out(if_data_out), .if_done_out(if_done_out),
        .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in),
        .mem_wdata_in(mem_wdata_in), .mem_len_in(mem_len_in),
        .mem_rdata_out(mem_rdata_out), .mem_done_out(mem_done_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_stall_req_out(if_stall_req_out), .mem_stall_req_out(mem_stall_req_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM attached to the DUT port, plus an independent reference of what memory should hold
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_ram [logic [31:0]];

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : def_byte(a);
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    task automatic set_ram(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_ram[a] = b;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } beat_t;

    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];
    beat_t       exp_wr[$];
    logic [31:0] last_load_model = 32'd0;

    function automatic int nbytes(input logic [2:0] len);
        return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
        return v;
    endfunction

    task automatic push_mem(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] len);
        int n = nbytes(len);
        if (we) begin
            for (int k = 0; k < n; k++) begin
                beat_t b;
                b.a = a + 32'(k);
                b.d = wd[8*k +: 8];
                exp_wr.push_back(b);
                ref_ram[b.a] = b.d;
            end
            exp_mem.push_back(last_load_model);
        end else begin
            last_load_model = model_read(a, n);
            exp_mem.push_back(last_load_model);
        end
    endtask

    task automatic push_if(input logic [31:0] a);
        exp_if.push_back(model_read(a, 4));
    endtask

    task automatic drive(input bit di, input logic [31:0] ia, input bit dm, input bit we,
                         input logic [31:0] ma, input logic [31:0] wd, input logic [2:0] len);
        if_req_in    = di;
        if_addr_in   = ia;
        mem_req_in   = dm;
        mem_we_in    = we;
        mem_addr_in  = ma;
        mem_wdata_in = wd;
        mem_len_in   = len;
    endtask

    // Holds each request until its done pulse, reporting the cycle index (after acceptance) of each
    task automatic wait_done(input bit wi, input bit wm, output int ic, output int mc);
        bit pi = wi;
        bit pm = wm;
        ic = -1;
        mc = -1;
        for (int c = 0; c < 80 && (pi || pm); c++) begin
            @(negedge clk_in);
            if (pi && if_done_out)  begin ic = c; pi = 1'b0; end
            if (pm && mem_done_out) begin mc = c; pm = 1'b0; end
            #1;
            if (!pi) if_req_in = 1'b0;
            if (!pm) mem_req_in = 1'b0;
        end
        checks++;
        if (pi || pm) begin
            failures++;
            $display("FAIL wait_done: if_pending=%0d mem_pending=%0d, expected both completed", pi, pm);
            if_req_in  = 1'b0;
            mem_req_in = 1'b0;
        end
    endtask

    logic        rdy_seen = 1'b1;
    logic [31:0] last_if = 32'd0, last_mem = 32'd0, e_val;
    beat_t       e_beat;

    always @(posedge clk_in) rdy_seen <= rdy_in;

    always @(negedge clk_in) begin
        if (rst_in) begin
            last_if  = 32'd0;
            last_mem = 32'd0;
        end else begin
            chk("if_stall", if_stall_req_out, if_req_in & ~if_done_out);
            chk("mem_stall", mem_stall_req_out, mem_req_in & ~mem_done_out);
            chk("done_exclusive", if_done_out & mem_done_out, 1'b0);
            if (if_done_out) begin
                if (exp_if.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL if_done_unexpected: data %h, expected no completion", if_data_out);
                end else begin
                    e_val = exp_if.pop_front();
                    chk("if_data", if_data_out, e_val);
                    last_if = e_val;
                end
            end else begin
                chk("if_data_hold", if_data_out, last_if);
            end
            if (mem_done_out) begin
                if (exp_mem.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_done_unexpected: data %h, expected no completion", mem_rdata_out);
                end else begin
                    e_val = exp_mem.pop_front();
                    chk("mem_rdata", mem_rdata_out, e_val);
                    last_mem = e_val;
                end
            end else begin
                chk("mem_rdata_hold", mem_rdata_out, last_mem);
            end
            if (mem_wr && rdy_seen) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected: addr %h byte %h, expected no write", mem_a, mem_dout);
                end else begin
                    e_beat = exp_wr.pop_front();
                    chk("wr_addr", mem_a, e_beat.a);
                    chk("wr_byte", {24'd0, mem_dout}, {24'd0, e_beat.d});
                end
            end
        end
    end

    initial begin
        int ic, mc, kind, sel;
        bit we;
        logic [31:0] ma, ia, wd, wrap_seq [4];
        logic [2:0] len;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        drive(0, 32'd0, 0, 0, 32'd0, 32'd0, 3'd0);
        repeat (3) @(negedge clk_in);
        chk("rst_if_data", if_data_out, 32'd0);
        chk("rst_mem_rdata", mem_rdata_out, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_ctl", {if_done_out, mem_done_out, mem_wr}, 3'b000);
        chk("rst_dout", {24'd0, mem_dout}, 32'd0);
        rst_in = 1'b0;

        // Instruction fetch of a known word
        set_ram(32'h100, 8'h13); set_ram(32'h101, 8'h05);
        set_ram(32'h102, 8'h10); set_ram(32'h103, 8'h00);
        @(negedge clk_in); #1;
        push_if(32'h100);
        drive(1, 32'h100, 0, 0, 32'd0, 32'd0, 3'd0);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk_in);
            if (c < 4) chk("if_addr_seq", mem_a, 32'h100 + 32'(c));
            chk("if_no_wr", mem_wr, 1'b0);
            chk("if_done_timing", if_done_out, c == 5);
            if (c == 5) chk("if_word", if_data_out, 32'h00100513);
        end
        #1 if_req_in = 1'b0;

        // Single-byte store
        @(negedge clk_in); #1;
        push_mem(1, 32'h30000, 32'h41, 3'd1);
        drive(0, 32'd0, 1, 1, 32'h30000, 32'h41, 3'd1);
        @(negedge clk_in);
        chk("sb_beat", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h41});
        @(negedge clk_in);
        chk("sb_done", {mem_done_out, mem_wr}, 2'b10);
        #1 mem_req_in = 1'b0;

        // Simultaneous requests: the load goes first, then the fetch
        set_ram(32'h200, 8'hFF); set_ram(32'h201, 8'h80);
        @(negedge clk_in); #1;
        push_mem(0, 32'h200, 32'd0, 3'd2);
        push_if(32'h400);
        drive(1, 32'h400, 1, 0, 32'h200, 32'd0, 3'd2);
        wait_done(1, 1, ic, mc);
        chk("prio_mem_cycle", mc, 3);
        chk("prio_if_cycle", ic, 9);
        chk("prio_rdata", mem_rdata_out, 32'h000080FF);

        // Four-byte store paused by rdy_in for three cycles
        @(negedge clk_in); #1;
        push_mem(1, 32'h5000, 32'hA1B2C3D4, 3'd4);
        drive(0, 32'd0, 1, 1, 32'h5000, 32'hA1B2C3D4, 3'd4);
        for (int c = 0; c <= 8; c++) begin
            int b;
            logic [31:0] wdv;
            wdv = 32'hA1B2C3D4;
            @(negedge clk_in);
            b = (c <= 1) ? c : (c <= 4) ? 1 : c - 3;
            if (c <= 6) begin
                chk("stall_wr_beat", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h5000 + 32'(b), wdv[8*b +: 8]});
                chk("stall_no_done", mem_done_out, 1'b0);
            end else begin
                chk("stall_done", {mem_done_out, mem_wr}, {c == 7, 1'b0});
            end
            #1;
            if (c == 1) rdy_in = 1'b0;
            if (c == 4) rdy_in = 1'b1;
            if (c == 7) mem_req_in = 1'b0;
        end

        // Load crossing the top of the address space
        wrap_seq[0] = 32'hFFFFFFFE; wrap_seq[1] = 32'hFFFFFFFF;
        wrap_seq[2] = 32'h00000000; wrap_seq[3] = 32'h00000001;
        set_ram(32'hFFFFFFFE, 8'h11); set_ram(32'hFFFFFFFF, 8'h22);
        set_ram(32'h00000000, 8'h33); set_ram(32'h00000001, 8'h44);
        @(negedge clk_in); #1;
        push_mem(0, 32'hFFFFFFFE, 32'd0, 3'd4);
        drive(0, 32'd0, 1, 0, 32'hFFFFFFFE, 32'd0, 3'd4);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk_in);
            if (c < 4) chk("wrap_addr", mem_a, wrap_seq[c]);
            if (c == 5) chk("wrap_data", {mem_done_out, mem_rdata_out}, {1'b1, 32'h44332211});
        end
        #1 mem_req_in = 1'b0;

        // Reset during the third byte of a load aborts it silently
        @(negedge clk_in); #1;
        drive(0, 32'd0, 1, 0, 32'h700, 32'd0, 3'd4);
        for (int c = 0; c <= 2; c++) @(negedge clk_in);
        chk("abort_addr_before", mem_a, 32'h702);
        #1 rst_in = 1'b1;
        #1;
        chk("abort_bus", {mem_wr, mem_a}, {1'b0, 32'd0});
        chk("abort_no_done", mem_done_out, 1'b0);
        chk("abort_stall_follow", mem_stall_req_out, 1'b1);
        mem_req_in = 1'b0;
        #1 chk("abort_stall_drop", mem_stall_req_out, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        last_load_model = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            chk("abort_quiet", {mem_done_out, mem_wr}, 2'b00);
        end
        #1;
        push_mem(0, 32'h200, 32'd0, 3'd2);
        drive(0, 32'd0, 1, 0, 32'h200, 32'd0, 3'd2);
        wait_done(0, 1, ic, mc);
        chk("after_reset_cycle", mc, 3);

        // Randomized traffic against the reference byte map
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       ma = 32'h1000 + $urandom_range(0, 63);
                1:       ma = 32'hFFFFFFFC + $urandom_range(0, 3);
                2:       ma = $urandom;
                default: ma = 32'h30000 + $urandom_range(0, 15);
            endcase
            ia  = ($urandom_range(0, 1) == 1) ? ma + $urandom_range(0, 3) : $urandom;
            wd  = $urandom;
            len = 3'($urandom_range(0, 7));
            we  = (kind == 2) ? 1'b1 : (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk_in); #1;
            if (kind != 0) push_mem(we, ma, wd, len);
            if (kind == 0 || kind == 3) push_if(ia);
            drive(kind == 0 || kind == 3, ia, kind != 0, we, ma, wd, len);
            wait_done(kind == 0 || kind == 3, kind != 0, ic, mc);
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end

        repeat (3) @(negedge clk_in);
        chk("scoreboard_drained", exp_if.size() + exp_mem.size() + exp_wr.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
